// File: rtl/alu_pkg.sv
// Shared ALU package: funct3 encodings for the RV32M group, the
// sequential multiply/divide FSM states, and the combinational ALU
// control table so both execute-stage ALUs decode from one place.
package alu_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] MUL_OP    = 3'b000;
  localparam logic [2:0] MULH_OP   = 3'b001;
  localparam logic [2:0] MULHSU_OP = 3'b010;
  localparam logic [2:0] MULHU_OP  = 3'b011;
  localparam logic [2:0] DIV_OP    = 3'b100;
  localparam logic [2:0] DIVU_OP   = 3'b101;
  localparam logic [2:0] REM_OP    = 3'b110;
  localparam logic [2:0] REMU_OP   = 3'b111;

  // Combinational ALU control table
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Multiply/divide sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    CALC  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out = en ? -in : in.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = en ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide). Valid/ready on both sides; busy while not IDLE.
// Optional build macro MULDIV_BYPASS_EN: trivial cases (divide by zero,
// signed divide overflow, multiply by zero) are resolved in PREP and
// skip the iterative loop.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             busy,
  output logic             dz
);

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;       // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_neg_q, quo_neg_q, rem_neg_q, dz_pend_q, byp_q;

  logic               is_div, b_zero, neg_a, neg_b;
  logic [WIDTH-1:0]   lo_in, hi_in, lo_out, hi_out;
  logic               lo_en, hi_en;
  logic [2*WIDTH-1:0] prod, acc_next;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   div_rem, fix_result;
  logic               div_fits;

  assign is_div = op_q[2];
  assign b_zero = (b_q == '0);
  assign neg_a  = a_is_signed(op_q) & a_q[WIDTH-1];
  assign neg_b  = b_is_signed(op_q) & b_q[WIDTH-1];

  // Share the two WIDTH negators: operand magnitudes in PREP, quotient/remainder sign fix in FIXUP
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    lo_in = acc_q[WIDTH-1:0];
    lo_en = quo_neg_q;
    hi_in = acc_q[2*WIDTH-1:WIDTH];
    hi_en = rem_neg_q;
    if (state_q == PREP) begin
      lo_in = a_q;
      lo_en = neg_a;
      hi_in = b_q;
      hi_en = neg_b;
    end
  end

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_lo (
    .en (lo_en),
    .in (lo_in),
    .out(lo_out)
  );

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_hi (
    .en (hi_en),
    .in (hi_in),
    .out(hi_out)
  );

  muldiv_negate #(.WIDTH(2 * WIDTH)) u_neg_prod (
    .en (mul_neg_q),
    .in (acc_q),
    .out(prod)
  );

  // One radix-2 iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, opnd_q};
    end
    // Shifted partial remainder needs one extra bit before the trial subtract
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_fits  = (div_trial >= {1'b0, opnd_q});
    div_rem   = div_trial[WIDTH-1:0] - opnd_q;
    if (is_div) begin
      acc_next = div_fits ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                          : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final result selection after sign correction
  always_comb begin
    case (op_q)
      MUL_OP:                       fix_result = prod[WIDTH-1:0];
      MULH_OP, MULHSU_OP, MULHU_OP: fix_result = prod[2*WIDTH-1:WIDTH];
      DIV_OP, DIVU_OP:              fix_result = lo_out;
      default:                      fix_result = hi_out;
    endcase
  end

`ifdef MULDIV_BYPASS_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             byp_hit, byp_dz;
  logic [WIDTH-1:0] byp_val;

  // Detect operations whose result is known without iterating
  always_comb begin
    byp_hit = 1'b0;
    byp_dz  = 1'b0;
    byp_val = '0;
    if (is_div) begin
      if (b_zero) begin
        byp_hit = 1'b1;
        byp_dz  = 1'b1;
        byp_val = op_q[1] ? a_q : '1;
      end else if (!op_q[0] && (a_q == MIN_VAL) && (b_q == '1)) begin
        byp_hit = 1'b1;
        byp_val = op_q[1] ? '0 : a_q;
      end
    end else if ((a_q == '0) || b_zero) begin
      byp_hit = 1'b1;
    end
  end
`endif

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too; this is flop storage, not a RAM, so the cost is negligible and X never escapes.
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      OUT       <= '0;
      dz        <= 1'b0;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      mul_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_pend_q <= 1'b0;
      byp_q     <= 1'b0;
    end else if (flush) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            a_q      <= DATA_A;
            b_q      <= DATA_B;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= PREP;
          end
        end
        PREP: begin
          // Divide: lo = dividend magnitude, opnd = divisor. Multiply: lo = multiplier, opnd = multiplicand.
          acc_q     <= is_div ? {{WIDTH{1'b0}}, lo_out} : {{WIDTH{1'b0}}, hi_out};
          opnd_q    <= is_div ? hi_out : lo_out;
          cnt_q     <= CNT_W'(WIDTH);
          mul_neg_q <= neg_a ^ neg_b;
          // An all-ones quotient from divide-by-zero must come out unnegated
          quo_neg_q <= (neg_a ^ neg_b) & ~b_zero;
          rem_neg_q <= neg_a;
          dz_pend_q <= is_div & b_zero;
          byp_q     <= 1'b0;
          state_q   <= CALC;
`ifdef MULDIV_BYPASS_EN
          if (byp_hit) begin
            // Result is loaded now; the pass through FIXUP only aligns out_valid
            OUT     <= byp_val;
            dz      <= byp_dz;
            byp_q   <= 1'b1;
            state_q <= FIXUP;
          end
`endif
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (!byp_q) begin
            OUT <= fix_result;
            dz  <= dz_pend_q;
          end
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
